// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM bus responder.
package sram_pkg;

    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_LANE_W = 16;
    localparam int SRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_WAIT  = 2'd2,
        READ_DRIVE = 2'd3
    } sram_resp_state_t;

endpackage

// File: rtl/sram_byte_array.sv
// MEM_WORDS x 32 storage split into two 16-bit lanes, with per-lane write
// enables and one asynchronous read port sharing the same index.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int MEM_WORDS = 2048,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                   clk,
    input  logic                   i_we_hi,
    input  logic                   i_we_lo,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic [SRAM_DATA_W-1:0] i_wdata,
    output logic [SRAM_DATA_W-1:0] o_rdata
);

    logic [SRAM_LANE_W-1:0] r_mem_hi [MEM_WORDS];
    logic [SRAM_LANE_W-1:0] r_mem_lo [MEM_WORDS];

    // NOTE: storage carries no reset; a reset on a large array defeats RAM inference and the contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (i_we_hi) r_mem_hi[i_idx] <= i_wdata[SRAM_DATA_W-1:SRAM_LANE_W];
        if (i_we_lo) r_mem_lo[i_idx] <= i_wdata[SRAM_LANE_W-1:0];
    end

    assign o_rdata = {r_mem_hi[i_idx], r_mem_lo[i_idx]};

endmodule

// File: rtl/sram_responder.sv
// Cycle-accurate SRAM bus responder with READ_LATENCY stable-address cycles before drive.
// Define SRAM_RESP_PROT_CHECK_EN to add the sticky protocol_err output and its checks.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = SRAM_ADDR_W,
    parameter int MEM_WORDS    = 2048,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_WIDTH-1:0]  SRAM_ADDR,
    input  logic                   SRAM_UB_N,
    input  logic                   SRAM_LB_N,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_OE_N
`ifdef SRAM_RESP_PROT_CHECK_EN
    ,
    output logic                   protocol_err
`endif
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [2:0] LAT   = 3'(READ_LATENCY);

    sram_resp_state_t       r_state, w_state_nxt;
    logic [2:0]             r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
    logic [SRAM_DATA_W-1:0] r_dout;
    logic                   w_load;

    logic                   w_sel, w_wr, w_rd, w_addr_match, w_drive;
    logic                   w_we_hi, w_we_lo;
    logic [SRAM_DATA_W-1:0] w_rdata, w_dq_out;

    assign w_sel        = !SRAM_CE_N;
    assign w_wr         = w_sel && !SRAM_WE_N;
    assign w_rd         = w_sel && SRAM_WE_N && !SRAM_OE_N;
    assign w_addr_match = (SRAM_ADDR == r_addr);

    // NOTE: gating the lane enables with the reset pin drops the write of an edge that lands while reset is held.
    assign w_we_hi = w_wr && rst && !SRAM_UB_N;
    assign w_we_lo = w_wr && rst && !SRAM_LB_N;

    sram_byte_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we_hi (w_we_hi),
        .i_we_lo (w_we_lo),
        .i_idx   (SRAM_ADDR[IDX_W-1:0]),
        .i_wdata (SRAM_DQ),
        .o_rdata (w_rdata)
    );

    // NOTE: every variable is given a default first so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_wr) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = SRAM_ADDR;
                end else if (w_rd) begin
                    w_state_nxt = READ_WAIT;
                    w_addr_nxt  = SRAM_ADDR;
                    w_cnt_nxt   = 3'd1;
                end
            end
            WRITE: begin
                if (w_wr) begin
                    w_addr_nxt = SRAM_ADDR;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            READ_WAIT: begin
                if (w_wr) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = SRAM_ADDR;
                end else if (!w_rd) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (!w_addr_match) begin
                    w_addr_nxt = SRAM_ADDR;
                    w_cnt_nxt  = 3'd1;
                end else if (r_cnt == LAT) begin
                    w_state_nxt = READ_DRIVE;
                    w_load      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            READ_DRIVE: begin
                if (w_wr) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = SRAM_ADDR;
                end else if (!w_rd) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (!w_addr_match) begin
                    // A moved address pays the full latency again.
                    w_state_nxt = READ_WAIT;
                    w_addr_nxt  = SRAM_ADDR;
                    w_cnt_nxt   = 3'd1;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            if (w_load) r_dout <= w_rdata;
        end
    end

    // Drive is qualified by the live pins so the bus is freed before the controller can drive it.
    assign w_drive  = (r_state == READ_DRIVE) && w_rd && w_addr_match;
    assign w_dq_out = {SRAM_UB_N ? {SRAM_LANE_W{1'b0}} : r_dout[SRAM_DATA_W-1:SRAM_LANE_W],
                       SRAM_LB_N ? {SRAM_LANE_W{1'b0}} : r_dout[SRAM_LANE_W-1:0]};
    assign SRAM_DQ  = w_drive ? w_dq_out : 'z;

`ifdef SRAM_RESP_PROT_CHECK_EN
    logic w_xz_hit;
    logic r_prot_err;

`ifndef SYNTHESIS
    assign w_xz_hit = w_wr &&
        ((!SRAM_UB_N && $isunknown(SRAM_DQ[SRAM_DATA_W-1:SRAM_LANE_W])) ||
         (!SRAM_LB_N && $isunknown(SRAM_DQ[SRAM_LANE_W-1:0])));
`else
    assign w_xz_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prot_err <= 1'b0;
        end else if (((r_state == WRITE) && w_wr && !w_addr_match) || w_xz_hit) begin
            r_prot_err <= 1'b1;
        end
    end

    assign protocol_err = r_prot_err;
`endif

endmodule

// File: doc/sram_responder.md
# sram_responder

Cycle-accurate, synthesizable responder for the 32-bit asynchronous-style SRAM bus driven by the MEM-stage SRAM controller. It sits on the far side of the `SRAM_*` pins, in place of the board SRAM, in simulation and FPGA self-test builds. It stores words in an internal byte-enabled array and honours write strobes. It returns read data on the shared bidirectional `SRAM_DQ` bus after a configurable number of stable-address cycles, so controller wait-cycle settings can be exercised against a known-slow memory.

## Interface
- `ADDR_WIDTH`, 17: width of `SRAM_ADDR`.
- `MEM_WORDS`, 2048: array depth in 32-bit words; power of two, ≤ 2**ADDR_WIDTH.
- `READ_LATENCY`, 2: stable-address cycles before read data is driven; range 1..7.

- `clk`  in  1  system clock; all sampling on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `SRAM_DQ`  inout  32  shared data bus; responder drives only in read-drive state.
- `SRAM_ADDR`  in  ADDR_WIDTH  word address.
- `SRAM_UB_N`  in  1  active-low byte-lane enable for `[31:16]`.
- `SRAM_LB_N`  in  1  active-low byte-lane enable for `[15:0]`.
- `SRAM_WE_N`  in  1  active-low write strobe.
- `SRAM_CE_N`  in  1  active-low chip enable.
- `SRAM_OE_N`  in  1  active-low output enable.
- `protocol_err`  out  1  sticky error flag; present only with `SRAM_RESP_PROT_CHECK_EN`.

## Operation
- Index = `SRAM_ADDR mod MEM_WORDS`. Upper address bits are ignored, so addresses wrap.
- FSM states: `IDLE`, `WRITE`, `READ_WAIT`, `READ_DRIVE`.
- `sel` = !CE_N. `wr` = sel & !WE_N. `rd` = sel & WE_N & !OE_N.
- `IDLE`:
  - `wr` → `WRITE`.
  - `rd` → `READ_WAIT`, latch address, counter = 1.
  - else stay.
- `WRITE`: every cycle with `wr` sampled, write `SRAM_DQ` lanes whose UB/LB enable is low into the array. Repeated writes of the same word are idempotent. `!wr` → `IDLE`.
- `READ_WAIT`:
  - `wr` → `WRITE`; write wins over any read.
  - `!rd` → `IDLE`.
  - Address differs from latched address → relatch, counter = 1.
  - Counter == READ_LATENCY → `READ_DRIVE` and load output register from array; else counter+1.
- `READ_DRIVE`:
  - Output register is reloaded each cycle from the current address, so a changed address costs exactly READ_LATENCY again: go to `READ_WAIT` and release the bus.
  - `wr` → `WRITE`; `!rd` → `IDLE`.
- DQ drive enable = (state == `READ_DRIVE`) & `rd` & address == latched address. It is gated combinationally by the live pins, so the responder releases the bus in the same cycle WE_N falls. Bus contention with the controller's write drive is therefore impossible.
- Driven lanes whose UB/LB enable is high drive 0. The whole bus is `z` when not driving.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset values:
  - state `IDLE`, counter 0.
  - drive enable 0, so `SRAM_DQ` = `z`.
  - output register 0.
  - `protocol_err` 0.
- Read latency: address presented with `rd` sampled at edge N → `SRAM_DQ` valid after edge N+READ_LATENCY. It stays valid while the address and `rd` hold.
- Write: lanes are committed at every edge with `wr` sampled. The last commit wins.
- Read of a word written in the immediately preceding write cycle returns the new data.
- Reset asserted mid-read: bus released asynchronously; FSM returns to `IDLE`.
- Reset asserted mid-write: the in-flight edge's write is dropped; earlier commits are kept.

## Configuration
- `SRAM_RESP_PROT_CHECK_EN` defined:
  - Adds the `protocol_err` port.
  - It is set sticky (cleared only by reset) when, during `WRITE`, the address changes between consecutive `wr` cycles.
  - It is also set when `SRAM_DQ` contains X/Z on an enabled lane while `wr` is sampled; this second check is simulation only and ignored in synthesis.
- Undefined: no port, no checking logic. Behaviour is otherwise identical.

## Structure
- Shared package `sram_pkg`:
  - state enum `sram_resp_state_t`.
  - `SRAM_DATA_W` = 32.
  - lane widths (`SRAM_LANE_W` = 16).
  - default `SRAM_ADDR_W` = 17.
- Sub-module `sram_byte_array`: MEM_WORDS×32 array with two lane write enables and one asynchronous read port. The FSM, counter and bus drive stay in the top.

## Test plan
- Reset with rst=0 → `SRAM_DQ` = z, state `IDLE`; release, then 10 idle cycles → bus stays z.
- Write 0xDEADBEEF to addr 5 (WE_N low 6 cycles, UB/LB low), then read addr 5 with READ_LATENCY=2 → DQ = 0xDEADBEEF exactly 2 edges after first read sample, z before.
- Byte lanes: write 0x11112222 to addr 7, then write 0xAAAABBBB with UB_N=1 → read returns 0x1111BBBB.
- Wrap: MEM_WORDS=2048, write 0x12345678 at addr 0x00005 → read at 0x00805 returns 0x12345678.
- Read at addr 3, change address to 4 on edge 1 of wait → DQ stays z until 2 edges after the change, then shows mem[4]. WE_N falling mid-drive → DQ released in the same cycle, no X on bus.
- With `SRAM_RESP_PROT_CHECK_EN`: change SRAM_ADDR from 9 to 10 while WE_N stays low → `protocol_err` = 1 and holds until reset.
